uart_tx_dev: RTL and testbench
==============================

# uart_tx_dev

Memory-mapped UART transmitter peripheral. It sits behind the system bridge alongside the two timer devices and accepts word writes from the CPU's memory stage. It buffers bytes in a small FIFO and serialises them 8N1 on `txd`. It raises a level interrupt on a free HWInt line when the transmit path drains.

## Interface
Parameters:
- `FIFO_DEPTH`, 8, byte FIFO entries; power of two, 2..64
- `DIV_W`, 16, width of the baud divisor register
- `DEFAULT_DIV`, 16, divisor value loaded at reset; clock cycles per serial bit

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `Addr`  in  30  word address, CPU byte address [31:2]; only `Addr[3:2]` decoded, bridge handles the base range
- `WE`  in  1  write enable from bridge, sampled at `clk` rising edge
- `Din`  in  32  write data
- `Dout`  out  32  combinational read data for register `Addr[3:2]`
- `txd`  out  1  serial output, idle high
- `IRQ`  out  1  level interrupt to CPU HWInt

## Operation
Register map by `Addr[3:2]`:
- 0 TXDATA: write pushes `Din[7:0]`; reads 0.
- 1 STATUS: read `{27'b0, ovf, busy, full, empty, irq}`; any write clears `ovf`.
- 2 CTRL: bits [1:0] = `{irq_en, en}`, read/write; other bits read 0.
- 3 DIV: `[DIV_W-1:0]` read/write; upper bits read 0.

Register effects:
- Effective divisor `d = (DIV==0) ? 1 : DIV`, latched into the frame at the START entry. Writing DIV mid-frame affects only the next frame.
- FIFO push: on a TXDATA write when `count<FIFO_DEPTH`, or when full with a pop in the same cycle. Otherwise the byte is dropped and `ovf` is set (sticky).
- FIFO pop: in IDLE when `en=1` and `count>0`; the popped byte is loaded into the shift register.

FSM (states IDLE, START, DATA, STOP; `bitcnt` 3 bits, `baud` DIV_W bits):
- IDLE: `txd=1`. A pop moves to START with `baud=d-1`.
- START: `txd=0`. At `baud==0`, go to DATA with `bitcnt=0` and `baud=d-1`; otherwise decrement `baud`.
- DATA: `txd=shift[0]` (LSB first). At `baud==0`, shift right; if `bitcnt==7` go to STOP, else increment `bitcnt`; reload `baud`.
- STOP: `txd=1`. At `baud==0`, go to IDLE.
- Frame length is exactly 10·d cycles.
- Clearing `en` mid-frame completes the current frame, then holds in IDLE with the FIFO retained.

Status and interrupt:
- `busy = (state!=IDLE)`. `empty = (count==0)`. `full = (count==FIFO_DEPTH)`.
- `irq = irq_en & empty & ~busy`, registered; `IRQ` equals `irq`.
- The interrupt handler clears it by pushing data or clearing `irq_en`.

Reset (asynchronous, `reset`=0): state IDLE, `txd=1`, `IRQ=0`, FIFO empty, `ovf=0`, CTRL=0, DIV=DEFAULT_DIV, shift/bitcnt/baud=0.

## Timing
- All state updates on `clk` rising edge; asynchronous clear on `reset` falling.
- `Dout` is combinational from `Addr` and current registers, with zero-cycle read latency, so the bridge can mux it in the same cycle.
- TXDATA write at edge N: `count` increments after N. With `en=1` and IDLE, the pop happens at edge N+1, and `txd` goes low after N+1. The first start bit appears 1 cycle after the write edge.
- Back-to-back frames: STOP exit at edge M and, with FIFO non-empty, the pop at edge M+1, leaving 1 idle-high cycle between frames.
- `IRQ` lags its condition by 1 cycle: it rises 1 cycle after STOP→IDLE with an empty FIFO, and falls 1 cycle after a push.
- CTRL/DIV writes are visible on `Dout` the cycle after the write edge.
- Reset asserted mid-frame: `txd` returns to 1 immediately, the FIFO contents are discarded, and no partial-frame completion occurs.

## Test plan
- Reset, then read all registers: STATUS=0x02, CTRL=0, DIV=16, `txd=1`, `IRQ=0`.
- DIV=4, CTRL=1, write 0x55 → `txd` low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop high for 4 cycles; frame total 40 cycles; busy=0 afterwards.
- DIV=0 with 0xA3: each bit lasts 1 cycle; 10-cycle frame, `txd` sequence 0,1,1,0,0,0,1,0,1,1.
- CTRL=0, write 9 bytes with FIFO_DEPTH=8 → full=1, ovf=1, count=8. Write STATUS → ovf=0. Set en=1 → 8 frames emitted in order with 1 idle cycle between them.
- CTRL=3, DIV=2, write 0x0F → `IRQ` low during the frame, high 1 cycle after the frame ends. A push drops `IRQ` 1 cycle later.
- Mid-frame: DIV write takes effect next frame; clearing `en` finishes the frame and holds the remaining bytes; `reset` low mid-DATA forces `txd=1` and the FIFO empty asynchronously.

Source files
------------

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable bit divisor and a
// level interrupt raised when the transmit path has fully drained.
module uart_tx_dev #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        txd,
  output logic        IRQ
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef enum logic [1:0] {REG_TXDATA, REG_STATUS, REG_CTRL, REG_DIV} reg_sel_t;

  state_t           state, state_nxt;
  reg_sel_t         sel;
  logic [7:0]       shift, shift_nxt;
  logic [2:0]       bitcnt, bitcnt_nxt;
  logic [DIV_W-1:0] baud, baud_nxt, frame_div, frame_div_nxt, div_reg, div_eff;
  logic             txd_nxt;
  logic             en, irq_en, ovf, irq_q;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             busy, empty, full, push, pop;
  logic             wr_txdata, wr_status, wr_ctrl, wr_div;
  logic             unused_bits;

  // Only the register select is decoded; the bridge owns the base range.
  assign sel         = reg_sel_t'(Addr[3:2]);
  assign unused_bits = ^{Addr[29:4], Addr[1:0], Din};

  assign wr_txdata = WE && (sel == REG_TXDATA);
  assign wr_status = WE && (sel == REG_STATUS);
  assign wr_ctrl   = WE && (sel == REG_CTRL);
  assign wr_div    = WE && (sel == REG_DIV);

  assign busy    = (state != IDLE);
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign pop     = (state == IDLE) && en && !empty;
  assign push    = wr_txdata && (!full || pop);
  assign div_eff = (div_reg == '0) ? DIV_ONE : div_reg;

  // NOTE: the byte array has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Din[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_status)             ovf <= 1'b0;
      else if (wr_txdata && !push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      div_reg <= DIV_W'(DEFAULT_DIV);
      irq_q   <= 1'b0;
    end else begin
      if (wr_ctrl) {irq_en, en} <= Din[1:0];
      if (wr_div)  div_reg      <= Din[DIV_W-1:0];
      irq_q <= irq_en && empty && !busy;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift;
    bitcnt_nxt    = bitcnt;
    baud_nxt      = baud;
    frame_div_nxt = frame_div;
    case (state)
      IDLE: if (pop) begin
        state_nxt     = START;
        shift_nxt     = mem[rd_ptr];
        frame_div_nxt = div_eff;
        baud_nxt      = div_eff - DIV_ONE;
      end
      START: if (baud == '0) begin
        state_nxt  = DATA;
        bitcnt_nxt = 3'd0;
        baud_nxt   = frame_div - DIV_ONE;
      end else begin
        baud_nxt = baud - DIV_ONE;
      end
      DATA: if (baud == '0) begin
        shift_nxt = {1'b0, shift[7:1]};
        baud_nxt  = frame_div - DIV_ONE;
        if (bitcnt == 3'd7) state_nxt  = STOP;
        else                bitcnt_nxt = bitcnt + 3'd1;
      end else begin
        baud_nxt = baud - DIV_ONE;
      end
      STOP: if (baud == '0) state_nxt = IDLE;
            else            baud_nxt  = baud - DIV_ONE;
      default: state_nxt = IDLE;
    endcase

    // Line level is registered from the next state so txd is glitch-free.
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      bitcnt    <= '0;
      baud      <= '0;
      frame_div <= DIV_ONE;
      txd       <= 1'b1;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      bitcnt    <= bitcnt_nxt;
      baud      <= baud_nxt;
      frame_div <= frame_div_nxt;
      txd       <= txd_nxt;
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    case (sel)
      REG_STATUS: Dout = {27'd0, ovf, busy, full, empty, irq_q};
      REG_CTRL:   Dout = {30'd0, irq_en, en};
      REG_DIV:    Dout = 32'(div_reg);
      default:    Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev: register map, frame timing,
// FIFO overflow, interrupt latency, mid-frame control changes and async reset.
module tb_uart_tx_dev;
  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        txd;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_DIV    = 2'd3;

  uart_tx_dev #(.FIFO_DEPTH(8), .DIV_W(16), .DEFAULT_DIV(16)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
    .Dout(Dout), .txd(txd), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line level for bit slot idx of a frame: start, 8 data LSB first, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Called at a falling edge; the write lands on the next rising edge and
  // the task returns at the falling edge after it.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
    Addr = {26'd0, a, 2'b00};
    Din  = data;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] data);
    Addr = {26'd0, a, 2'b00};
    WE   = 1'b0;
    #1;
    data = Dout;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    bus_read(A_TXDATA, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_txdata: got %h want %h", r, 32'h0); end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h want %h", r, 32'h2); end
    bus_read(A_CTRL, r);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want %h", r, 32'h0); end
    bus_read(A_DIV, r);
    n_checks++; if (r !== 32'd16) begin n_fail++; $display("FAIL reset_div: got %h want %h", r, 32'd16); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    @(negedge clk);
  endtask

  task automatic test_basic_frame;
    logic [31:0] r;
    bus_write(A_DIV, 32'd4);
    bus_write(A_CTRL, 32'd1);
    bus_write(A_TXDATA, 32'h55);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== exp_bit(8'h55, i / 4)) begin
        n_fail++; $display("FAIL basic_frame cyc %0d: txd=%b want %b", i, txd, exp_bit(8'h55, i / 4));
      end
      if (i == 20) begin
        bus_read(A_STATUS, r);
        n_checks++; if (r !== 32'h0A) begin n_fail++; $display("FAIL basic_busy: got %h want %h", r, 32'h0A); end
      end
    end
    @(negedge clk);
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h02) begin n_fail++; $display("FAIL basic_done_status: got %h want %h", r, 32'h02); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL basic_idle_txd: got %b want 1", txd); end
  endtask

  task automatic test_div_zero;
    logic [31:0] r;
    bus_write(A_DIV, 32'd0);
    bus_read(A_DIV, r);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL div0_readback: got %h want %h", r, 32'd0); end
    bus_write(A_TXDATA, 32'hA3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== exp_bit(8'hA3, i)) begin
        n_fail++; $display("FAIL div0_frame cyc %0d: txd=%b want %b", i, txd, exp_bit(8'hA3, i));
      end
    end
    @(negedge clk);
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h02) begin n_fail++; $display("FAIL div0_done_status: got %h want %h", r, 32'h02); end
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    logic [7:0]  b;
    bus_write(A_CTRL, 32'd0);
    bus_write(A_DIV, 32'd2);
    for (int k = 0; k < 9; k++) bus_write(A_TXDATA, 32'h10 + 32'(k));
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h14) begin n_fail++; $display("FAIL ovf_full_status: got %h want %h", r, 32'h14); end
    bus_write(A_STATUS, 32'h0);
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h04) begin n_fail++; $display("FAIL ovf_cleared: got %h want %h", r, 32'h04); end
    bus_write(A_CTRL, 32'd1);
    for (int f = 0; f < 8; f++) begin
      b = 8'h10 + 8'(f);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        n_checks++;
        if (txd !== exp_bit(b, i / 2)) begin
          n_fail++; $display("FAIL burst frame %0d cyc %0d: txd=%b want %b", f, i, txd, exp_bit(b, i / 2));
        end
        if (f == 0 && i == 1) begin
          bus_read(A_STATUS, r);
          n_checks++; if (r !== 32'h08) begin n_fail++; $display("FAIL burst_after_pop: got %h want %h", r, 32'h08); end
        end
      end
      @(negedge clk);
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL burst_gap %0d: txd=%b want 1", f, txd); end
    end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h02) begin n_fail++; $display("FAIL burst_done_status: got %h want %h", r, 32'h02); end
  endtask

  task automatic test_irq;
    bus_write(A_DIV, 32'd2);
    bus_write(A_CTRL, 32'd3);
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_lag_enable: got %b want 0", IRQ); end
    bus_write(A_TXDATA, 32'h0F);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_pre_push: got %b want 1", IRQ); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (IRQ !== 1'b0 || txd !== exp_bit(8'h0F, i / 2)) begin
        n_fail++; $display("FAIL irq_frame cyc %0d: IRQ=%b txd=%b want IRQ=0 txd=%b", i, IRQ, txd, exp_bit(8'h0F, i / 2));
      end
    end
    @(negedge clk);
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_stop_exit: got %b want 0", IRQ); end
    @(negedge clk);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", IRQ); end
    bus_write(A_TXDATA, 32'h81);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_push_lag: got %b want 1", IRQ); end
    @(negedge clk);
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_push_fall: got %b want 0", IRQ); end
    repeat (20) @(negedge clk);
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_second_exit: got %b want 0", IRQ); end
    @(negedge clk);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_second_rise: got %b want 1", IRQ); end
    bus_write(A_CTRL, 32'd1);
    n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_disable_lag: got %b want 1", IRQ); end
    @(negedge clk);
    n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_disable_fall: got %b want 0", IRQ); end
  endtask

  task automatic test_midframe;
    logic [31:0] r;
    bus_write(A_CTRL, 32'd0);
    bus_write(A_DIV, 32'd2);
    bus_write(A_TXDATA, 32'h3C);
    bus_write(A_TXDATA, 32'hC3);
    bus_write(A_TXDATA, 32'h5A);
    bus_write(A_TXDATA, 32'h77);
    bus_write(A_CTRL, 32'd1);
    // Frame 1 keeps d=2 even though DIV is rewritten to 3 inside it.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== exp_bit(8'h3C, i / 2)) begin
        n_fail++; $display("FAIL mid_div_frame1 cyc %0d: txd=%b want %b", i, txd, exp_bit(8'h3C, i / 2));
      end
      if (i == 6) begin Addr = {26'd0, A_DIV, 2'b00}; Din = 32'd3; WE = 1'b1; end
      else WE = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL mid_gap1: txd=%b want 1", txd); end
    // Frame 2 uses d=3; en is cleared inside it and must not cut it short.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== exp_bit(8'hC3, i / 3)) begin
        n_fail++; $display("FAIL mid_div_frame2 cyc %0d: txd=%b want %b", i, txd, exp_bit(8'hC3, i / 3));
      end
      if (i == 4) begin Addr = {26'd0, A_CTRL, 2'b00}; Din = 32'd0; WE = 1'b1; end
      else WE = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL mid_hold cyc %0d: txd=%b want 1", i, txd); end
    end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h00) begin n_fail++; $display("FAIL mid_hold_status: got %h want %h", r, 32'h00); end
    bus_read(A_DIV, r);
    n_checks++; if (r !== 32'd3) begin n_fail++; $display("FAIL mid_div_readback: got %h want %h", r, 32'd3); end
    @(negedge clk);
    bus_write(A_CTRL, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== exp_bit(8'h5A, i / 3)) begin
        n_fail++; $display("FAIL mid_resume cyc %0d: txd=%b want %b", i, txd, exp_bit(8'h5A, i / 3));
      end
    end
    // Asynchronous reset in the middle of a low data bit.
    #2 reset = 1'b0;
    #1;
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL async_reset_txd: got %b want 1", txd); end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h02) begin n_fail++; $display("FAIL async_reset_status: got %h want %h", r, 32'h02); end
    bus_read(A_DIV, r);
    n_checks++; if (r !== 32'd16) begin n_fail++; $display("FAIL async_reset_div: got %h want %h", r, 32'd16); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_write(A_CTRL, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle cyc %0d: txd=%b want 1", i, txd); end
    end
    bus_read(A_STATUS, r);
    n_checks++; if (r !== 32'h02) begin n_fail++; $display("FAIL post_reset_status: got %h want %h", r, 32'h02); end
  endtask

  initial begin
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic_frame;
    test_div_zero;
    test_overflow;
    test_irq;
    test_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
